// File: rtl/uart_pkg.sv
// Shared constants for the UART report path: ASCII characters and the report frame length.
package uart_pkg;

  localparam logic [7:0] CH_W   = 8'h57;
  localparam logic [7:0] CH_S   = 8'h53;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_COL = 8'h3A;
  localparam logic [7:0] CH_DOT = 8'h2E;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_0   = 8'h30;

  localparam int         FRAME_LEN = 12;
  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

endpackage

// File: rtl/bin2ascii2.sv
// Converts a 7-bit binary value to two ASCII decimal digits; values above 99 show as "99".
module bin2ascii2
  import uart_pkg::*;
(
  input  logic [6:0] bin,
  output logic [7:0] tens,
  output logic [7:0] ones
);

  logic [6:0] sat;

  assign sat  = (bin > 7'd99) ? 7'd99 : bin;
  assign tens = CH_0 + 8'(sat / 7'd10);
  assign ones = CH_0 + 8'(sat % 7'd10);

endmodule

// File: rtl/uart_report_tx.sv
// Formats a snapshot of watch/stopwatch time as a 12-byte ASCII frame and streams it to uart_tx.
// Optional periodic reporting is compiled in with `define UART_AUTO_REPORT_EN.
module uart_report_tx
  import uart_pkg::*;
#(
  parameter int AUTO_PERIOD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_req,
  input  logic       mode,
  input  logic [4:0] t_hour,
  input  logic [5:0] t_min,
  input  logic [5:0] t_sec,
  input  logic [6:0] t_msec,
  input  logic       tx_busy,
  input  logic       tx_done,
`ifdef UART_AUTO_REPORT_EN
  input  logic       auto_en,
`endif
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       report_busy,
  output logic       frame_done,
  output logic [1:0] state_dbg
);

  // Handshake with uart_tx: a byte is launched only while tx_busy=0, by a one-cycle tx_start
  // with tx_data held until the next launch; the byte is complete on the tx_done pulse.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

  state_t     state, state_n;
  logic [3:0] idx;
  logic       pending, mode_q;
  logic [6:0] fa_q, fb_q, fc_q;
  logic [7:0] a_t, a_o, b_t, b_o, c_t, c_o, cur_byte;
  logic       req, auto_req, pend_eff, load, fire, next_done, last_done;

  if (AUTO_PERIOD < 1 || AUTO_PERIOD > 59) begin : g_bad_period
    $error("AUTO_PERIOD must be within 1..59");
  end

`ifdef UART_AUTO_REPORT_EN
  logic [5:0] sec_prev, per_cnt;
  logic       tick;

  assign tick     = auto_en && !mode && (t_sec != sec_prev);
  assign auto_req = tick && (per_cnt == 6'(AUTO_PERIOD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_prev <= '0;
      per_cnt  <= '0;
    end else begin
      sec_prev <= t_sec;
      if (tick) per_cnt <= auto_req ? 6'd0 : per_cnt + 6'd1;
    end
  end
`else
  assign auto_req = 1'b0;
`endif

  assign req = send_req | auto_req;

  bin2ascii2 u_conv_a (.bin(fa_q), .tens(a_t), .ones(a_o));
  bin2ascii2 u_conv_b (.bin(fb_q), .tens(b_t), .ones(b_o));
  bin2ascii2 u_conv_c (.bin(fc_q), .tens(c_t), .ones(c_o));

  always_comb begin
    cur_byte = CH_LF;
    case (idx)
      4'd0:    cur_byte = mode_q ? CH_S : CH_W;
      4'd1:    cur_byte = CH_SP;
      4'd2:    cur_byte = a_t;
      4'd3:    cur_byte = a_o;
      4'd4:    cur_byte = CH_COL;
      4'd5:    cur_byte = b_t;
      4'd6:    cur_byte = b_o;
      4'd7:    cur_byte = mode_q ? CH_DOT : CH_COL;
      4'd8:    cur_byte = c_t;
      4'd9:    cur_byte = c_o;
      4'd10:   cur_byte = CH_CR;
      default: cur_byte = CH_LF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (req) state_n = S_LOAD;
      S_LOAD:  state_n = S_START;
      S_START: if (!tx_busy) state_n = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          if (idx != LAST_IDX) state_n = S_START;
          else                 state_n = pend_eff ? S_LOAD : S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    load      = (state == S_LOAD);
    fire      = (state == S_START) && !tx_busy;
    next_done = (state == S_WAIT) && tx_done && (idx != LAST_IDX);
    last_done = (state == S_WAIT) && tx_done && (idx == LAST_IDX);
    // A request arriving with the final tx_done still counts as queued.
    pend_eff  = pending || (req && (state != S_IDLE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      report_busy <= 1'b0;
      frame_done  <= 1'b0;
      idx         <= 4'd0;
      pending     <= 1'b0;
      mode_q      <= 1'b0;
      fa_q        <= '0;
      fb_q        <= '0;
      fc_q        <= '0;
    end else begin
      tx_start   <= fire;
      frame_done <= last_done;
      if (load) begin
        mode_q      <= mode;
        fa_q        <= mode ? {1'b0, t_min} : {2'b0, t_hour};
        fb_q        <= {1'b0, mode ? t_sec : t_min};
        fc_q        <= mode ? t_msec : {1'b0, t_sec};
        idx         <= 4'd0;
        report_busy <= 1'b1;
      end
      if (fire)      tx_data <= cur_byte;
      if (next_done) idx <= idx + 4'd1;
      if (last_done) begin
        report_busy <= 1'b0;
        pending     <= 1'b0;
      end else if (req && (state != S_IDLE)) begin
        pending <= 1'b1;
      end
    end
  end

  assign state_dbg = state;

endmodule
